// File: rtl/s3_chien_forney.sv
// -----------------------------------------------------------------------------
// s3_chien_forney
// Error-location / error-evaluation stage of the RS decoder, fed by the KES
// stage. Lambda(x) (deg<=2) and Omega(x) (deg<=1) are captured on kes_done.
// Lambda1 is then inverted over 7 cycles. After that, all N symbol positions
// are swept, highest index first, one position per clock. The Forney error
// value is emitted for every position.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   kes_done                  1-cycle pulse, coefficients valid this cycle
//   rs_lambda0..2             Lambda coefficients x^0..x^2 (any nonzero scale)
//   rs_omega0..1              Omega coefficients x^0..x^1 (same scale)
//   err_valid/err_idx/err_val one result per position, N-1 down to 0
//   err_last                  marks position 0
//   cs_busy                   high from capture through the DONE cycle
//   cs_done                   1-cycle pulse, cycle after err_last
//   dec_fail                  verdict, updated with cs_done, held until capture
//   cs_ovf                    1-cycle pulse when kes_done arrives while busy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for kes_done
// INV   | 7 square-and-multiply steps: acc -> lambda1^254 = 1/lambda1
// SWEEP | one Chien/Forney evaluation per cycle, j = N-1 .. 0
// DONE  | cs_done pulse and failure verdict
// -----------------------------------------------------------------------------
module s3_chien_forney #(
    parameter int N   = 255,
    parameter int FCR = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       kes_done,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic       err_valid,
    output logic [7:0] err_idx,
    output logic [7:0] err_val,
    output logic       err_last,
    output logic       cs_busy,
    output logic       cs_done,
    output logic       dec_fail,
    output logic       cs_ovf
);

    // GF(2^8) multiply, p(x) = x^8 + x^4 + x^3 + x^2 + 1
    function automatic logic [7:0] gf2m8_multi(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow_alpha(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = gf2m8_multi(r, 8'h02);
        return r;
    endfunction

    // Preload constants. The sweep starts at j = N-1, so Lambda is evaluated
    // at alpha^-(N-1) = alpha^(256-N), and each step multiplies the
    // evaluation point by alpha.
    localparam logic [7:0] A_PRE1 = gf_pow_alpha(256 - N);
    localparam logic [7:0] A_PRE2 = gf_pow_alpha(2 * (256 - N));
    localparam logic [7:0] X_INIT = gf_pow_alpha(N - 1);
    localparam logic [7:0] A_INV  = gf_pow_alpha(254);
    localparam logic [7:0] J_TOP  = 8'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INV   = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] inv_cnt;
    logic [7:0] j_pos;
    logic [7:0] l0r, l1r, l2r, o0r, o1r, xr;
    logic [7:0] sq, acc;
    logic [1:0] deg;
    logic [1:0] roots;
    logic       l0_zero, l1_zero, om_nz;

    logic [7:0] chien_sum;
    logic       root;
    logic [7:0] om_sum;
    logic [7:0] x_term;
    logic [7:0] fv_num;
    logic [7:0] fv;
    logic [7:0] sq2;
    logic       fail_now;

    always_comb begin
        chien_sum = l0r ^ l1r ^ l2r;
        root      = (chien_sum == 8'h00);
        om_sum    = o0r ^ o1r;
        x_term    = (FCR == 0) ? xr : 8'h01;
        fv_num    = gf2m8_multi(x_term, om_sum);
        // acc holds 1/Lambda'(x) = 1/lambda1 once INV is finished
        fv        = root ? gf2m8_multi(fv_num, acc) : 8'h00;
        sq2       = gf2m8_multi(sq, sq);
        fail_now  = l0_zero | (l1_zero & (deg == 2'd2)) | (roots != deg) |
                    ((deg == 2'd0) & om_nz);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            inv_cnt   <= 3'd0;
            j_pos     <= 8'h00;
            l0r       <= 8'h00;
            l1r       <= 8'h00;
            l2r       <= 8'h00;
            o0r       <= 8'h00;
            o1r       <= 8'h00;
            xr        <= 8'h00;
            sq        <= 8'h00;
            acc       <= 8'h00;
            deg       <= 2'd0;
            roots     <= 2'd0;
            l0_zero   <= 1'b0;
            l1_zero   <= 1'b0;
            om_nz     <= 1'b0;
            err_valid <= 1'b0;
            err_idx   <= 8'h00;
            err_val   <= 8'h00;
            err_last  <= 1'b0;
            cs_busy   <= 1'b0;
            cs_done   <= 1'b0;
            dec_fail  <= 1'b0;
            cs_ovf    <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            err_idx   <= 8'h00;
            err_val   <= 8'h00;
            err_last  <= 1'b0;
            cs_done   <= 1'b0;
            // a new codeword is only accepted in IDLE; anything else is dropped
            cs_ovf    <= kes_done & (state != IDLE);

            case (state)
                IDLE: begin
                    if (kes_done) begin
                        l0r      <= rs_lambda0;
                        l1r      <= gf2m8_multi(rs_lambda1, A_PRE1);
                        l2r      <= gf2m8_multi(rs_lambda2, A_PRE2);
                        o0r      <= rs_omega0;
                        o1r      <= gf2m8_multi(rs_omega1, A_PRE1);
                        xr       <= X_INIT;
                        sq       <= rs_lambda1;
                        acc      <= 8'h01;
                        deg      <= (rs_lambda2 != 8'h00) ? 2'd2 :
                                    (rs_lambda1 != 8'h00) ? 2'd1 : 2'd0;
                        l0_zero  <= (rs_lambda0 == 8'h00);
                        l1_zero  <= (rs_lambda1 == 8'h00);
                        om_nz    <= (rs_omega0 != 8'h00) | (rs_omega1 != 8'h00);
                        roots    <= 2'd0;
                        inv_cnt  <= 3'd0;
                        cs_busy  <= 1'b1;
                        dec_fail <= 1'b0;
                        state    <= INV;
                    end
                end

                INV: begin
                    // after step k: sq = l1^(2^k), acc = l1^(2^(k+1)-2)
                    sq      <= sq2;
                    acc     <= gf2m8_multi(acc, sq2);
                    inv_cnt <= inv_cnt + 3'd1;
                    if (inv_cnt == 3'd6) begin
                        j_pos <= J_TOP;
                        state <= SWEEP;
                    end
                end

                SWEEP: begin
                    err_valid <= 1'b1;
                    err_idx   <= j_pos;
                    err_val   <= fv;
                    err_last  <= (j_pos == 8'h00);
                    l1r       <= gf2m8_multi(l1r, 8'h02);
                    l2r       <= gf2m8_multi(l2r, 8'h04);
                    o1r       <= gf2m8_multi(o1r, 8'h02);
                    xr        <= gf2m8_multi(xr, A_INV);
                    if (root && (roots != 2'd3)) roots <= roots + 2'd1;
                    if (j_pos == 8'h00) begin
                        state <= DONE;
                    end else begin
                        j_pos <= j_pos - 8'h01;
                    end
                end

                DONE: begin
                    cs_done  <= 1'b1;
                    dec_fail <= fail_now;
                    cs_busy  <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s3_chien_forney.sv
// -----------------------------------------------------------------------------
// tb_s3_chien_forney
// Scoreboard bench for s3_chien_forney. There are two instances: N=255/FCR=0
// (index 0) and N=204/FCR=1 (index 1). Expected per-position tuples and
// verdicts are computed with a log/antilog GF model when a codeword is
// issued. A negedge monitor pops and compares them as the DUT emits output.
// -----------------------------------------------------------------------------
module tb_s3_chien_forney;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       kes [2];
    logic [7:0] l0, l1, l2, o0, o1;

    logic       ev   [2];
    logic [7:0] eidx [2];
    logic [7:0] eval [2];
    logic       el   [2];
    logic       busy [2];
    logic       done [2];
    logic       fail [2];
    logic       ovf  [2];

    always #5 clk = ~clk;

    s3_chien_forney #(.N(255), .FCR(0)) dut0 (
        .clk(clk), .rstn(rstn), .kes_done(kes[0]),
        .rs_lambda0(l0), .rs_lambda1(l1), .rs_lambda2(l2),
        .rs_omega0(o0), .rs_omega1(o1),
        .err_valid(ev[0]), .err_idx(eidx[0]), .err_val(eval[0]), .err_last(el[0]),
        .cs_busy(busy[0]), .cs_done(done[0]), .dec_fail(fail[0]), .cs_ovf(ovf[0])
    );

    s3_chien_forney #(.N(204), .FCR(1)) dut1 (
        .clk(clk), .rstn(rstn), .kes_done(kes[1]),
        .rs_lambda0(l0), .rs_lambda1(l1), .rs_lambda2(l2),
        .rs_omega0(o0), .rs_omega1(o1),
        .err_valid(ev[1]), .err_idx(eidx[1]), .err_val(eval[1]), .err_last(el[1]),
        .cs_busy(busy[1]), .cs_done(done[1]), .dec_fail(fail[1]), .cs_ovf(ovf[1])
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // GF(2^8) model via log/antilog tables
    logic [7:0] gexp [255];
    int         glog [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        return gexp[(255 - glog[a]) % 255];
    endfunction

    logic [16:0] exp_q [2][$];
    logic        df_q  [2][$];
    int          exp_done [2];
    int          n_done   [2];
    logic        prev_last [2];

    task automatic push_expect(input int d, input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [7:0] b0, input logic [7:0] b1);
        int n;
        int rcnt;
        int dg;
        logic [7:0] xi, xj, lam, val;
        logic f;
        n    = (d == 0) ? 255 : 204;
        rcnt = 0;
        for (int j = n - 1; j >= 0; j--) begin
            xi  = gexp[(255 - j) % 255];
            xj  = gexp[j % 255];
            lam = a0 ^ gm(a1, xi) ^ gm(a2, gm(xi, xi));
            val = 8'h00;
            if (lam == 8'h00) begin
                if (rcnt < 3) rcnt++;
                val = gm(gm((d == 0) ? xj : 8'h01, b0 ^ gm(b1, xi)), ginv(a1));
            end
            exp_q[d].push_back({(j == 0), 8'(j), val});
        end
        dg = (a2 != 8'h00) ? 2 : (a1 != 8'h00) ? 1 : 0;
        f  = (a0 == 8'h00) || (a1 == 8'h00 && dg == 2) || (rcnt != dg) ||
             (dg == 0 && (b0 != 8'h00 || b1 != 8'h00));
        df_q[d].push_back(f);
        exp_done[d]++;
    endtask

    task automatic issue(input int d, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] b0, input logic [7:0] b1,
                         input bit push);
        @(negedge clk);
        l0 = a0; l1 = a1; l2 = a2; o0 = b0; o1 = b1;
        kes[d] = 1'b1;
        if (push) push_expect(d, a0, a1, a2, b0, b1);
        @(posedge clk);
        #1 kes[d] = 1'b0;
    endtask

    task automatic drain(input int d, input string tag);
        for (int c = 0; c < 320; c++) begin
            if (exp_q[d].size() == 0 && df_q[d].size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_drain"}, 32'(exp_q[d].size() + df_q[d].size()), 32'd0);
        chk({tag, "_ndone"}, 32'(n_done[d]), 32'(exp_done[d]));
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ev[d]) begin
                if (exp_q[d].size() == 0) chk("spurious_valid", 32'(ev[d]), 32'd0);
                else chk("err_tuple", 32'({el[d], eidx[d], eval[d]}), 32'(exp_q[d].pop_front()));
            end
            if (prev_last[d]) chk("done_after_last", 32'(done[d]), 32'd1);
            if (done[d]) begin
                n_done[d] <= n_done[d] + 1;
                if (df_q[d].size() != 0) chk("dec_fail", 32'(fail[d]), 32'(df_q[d].pop_front()));
            end
            prev_last[d] <= ev[d] & el[d];
        end
    end

    initial begin
        int k;
        logic [8:0] t;
        logic [7:0] v;
        logic [7:0] s, x1, x2;
        int p1, p2, n;

        kes[0] = 1'b0; kes[1] = 1'b0;
        l0 = 8'h00; l1 = 8'h00; l2 = 8'h00; o0 = 8'h00; o1 = 8'h00;
        for (int d = 0; d < 2; d++) begin
            exp_done[d]  = 0;
            n_done[d]    = 0;
            prev_last[d] = 1'b0;
        end
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = v;
            glog[v] = i;
            t = {v, 1'b0};
            if (t[8]) t = t ^ 9'h11D;
            v = t[7:0];
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk("reset_outs", 32'({ev[d], el[d], busy[d], done[d], fail[d], ovf[d], eidx[d], eval[d]}), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 1 no error
        issue(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        drain(0, "t1");
        // 2 single error at idx0
        issue(0, 8'h01, 8'h01, 8'h00, 8'h05, 8'h00, 1);
        drain(0, "t2");
        // 3 two errors, then scaled by 0x57
        issue(0, 8'h01, 8'h03, 8'h02, 8'h00, 8'h03, 1);
        drain(0, "t3");
        issue(0, 8'h57, gm(8'h03, 8'h57), gm(8'h02, 8'h57), 8'h00, gm(8'h03, 8'h57), 1);
        drain(0, "t3s");
        // 4 failures
        issue(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1);
        drain(0, "t4a");
        issue(0, 8'h00, 8'h03, 8'h02, 8'h00, 8'h03, 1);
        drain(0, "t4b");

        // 5 latency and overrun
        issue(0, 8'h01, 8'h03, 8'h02, 8'h00, 8'h03, 1);
        for (k = 1; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (ev[0]) break;
        end
        chk("latency", 32'(k), 32'd8);
        chk("busy_sweep", 32'(busy[0]), 32'd1);
        repeat (11) @(posedge clk);
        issue(0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 0);
        chk("cs_ovf", 32'(ovf[0]), 32'd1);
        @(posedge clk);
        #1 chk("cs_ovf_clear", 32'(ovf[0]), 32'd0);
        drain(0, "t5");

        // 6 reset mid-sweep at idx 100
        issue(0, 8'h01, 8'h03, 8'h02, 8'h00, 8'h03, 1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (ev[0] && eidx[0] == 8'd100) break;
        end
        chk("reach_idx100", 32'(eidx[0]), 32'd100);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk("rst_outs", 32'({ev[0], el[0], busy[0], done[0], fail[0], ovf[0], eidx[0], eval[0]}), 32'd0);
        exp_q[0].delete();
        df_q[0].delete();
        exp_done[0]--;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", 32'(n_done[0]), 32'(exp_done[0]));
        issue(0, 8'h01, 8'h01, 8'h00, 8'h05, 8'h00, 1);
        drain(0, "t6");

        // shortened code N=204, FCR=1
        issue(1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        drain(1, "s1");
        issue(1, 8'h01, 8'h03, 8'h02, 8'h07, 8'h03, 1);
        drain(1, "s2");

        // random two-error locators on both instances
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 2; d++) begin
                n  = (d == 0) ? 255 : 204;
                p1 = int'($urandom_range(n - 1));
                p2 = int'($urandom_range(n - 1));
                if (p2 == p1) p2 = (p1 + 1) % n;
                x1 = gexp[p1];
                x2 = gexp[p2];
                s  = 8'($urandom_range(255, 1));
                issue(d, s, gm(s, x1 ^ x2), gm(s, gm(x1, x2)),
                      8'($urandom_range(255)), 8'($urandom_range(255)), 1);
                drain(d, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
